// File: rtl/load_image_pkg.sv
// Shared constants and state encoding for the 1280x1024 frame reader.
// Modules take their own parameters; these are the production defaults.
package load_image_pkg;

  localparam int WIDTH           = 1280;
  localparam int HEIGHT          = 1024;
  localparam int BURST_LEN       = 16;
  localparam int MAX_OUT         = 4;
  localparam int ADDR_W          = 32;
  localparam int BURSTS_PER_LINE = WIDTH / BURST_LEN;
  localparam int TOTAL_BURSTS    = HEIGHT * BURSTS_PER_LINE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/load_image_ar_gen.sv
// AXI read-address generator: walks the frame burst by burst using a row-base
// accumulator and throttles issue on the number of bursts still in flight.
module load_image_ar_gen #(
  parameter int WIDTH     = load_image_pkg::WIDTH,
  parameter int HEIGHT    = load_image_pkg::HEIGHT,
  parameter int BURST_LEN = load_image_pkg::BURST_LEN,
  parameter int MAX_OUT   = load_image_pkg::MAX_OUT,
  parameter int ADDR_W    = load_image_pkg::ADDR_W
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              start_i,
  input  logic              run_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [15:0]       stride_i,
  input  logic              r_last_hs_i,
  input  logic              arready_i,
  output logic              arvalid_o,
  output logic [ADDR_W-1:0] araddr_o
);
  import load_image_pkg::*;

  localparam int LINE_BURSTS  = WIDTH / BURST_LEN;
  localparam int FRAME_BURSTS = HEIGHT * LINE_BURSTS;
  localparam int BXW = (LINE_BURSTS > 1) ? $clog2(LINE_BURSTS) : 1;
  localparam int IW  = $clog2(FRAME_BURSTS + 1);
  localparam int OW  = $clog2(MAX_OUT + 1);

  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [15:0]       stride_q, stride_d;
  logic [BXW-1:0]    bx_q, bx_d;
  logic [IW-1:0]     issued_q, issued_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic              arvalid_q, arvalid_d;
  logic              ar_hs;

  assign ar_hs     = arvalid_q & arready_i;
  assign arvalid_o = arvalid_q;
  assign araddr_o  = row_base_q + ADDR_W'(bx_q) * ADDR_W'(BURST_LEN * 4);

  always_comb begin
    row_base_d = row_base_q;
    stride_d   = stride_q;
    bx_d       = bx_q;
    issued_d   = issued_q;
    outst_d    = outst_q;
    arvalid_d  = arvalid_q;
    if (start_i) begin
      row_base_d = base_addr_i;
      stride_d   = stride_i;
      bx_d       = '0;
      issued_d   = '0;
      outst_d    = '0;
      arvalid_d  = 1'b1;
    end else if (!run_i) begin
      arvalid_d = 1'b0;
    end else begin
      outst_d = outst_q + OW'(ar_hs) - OW'(r_last_hs_i);
      if (ar_hs) begin
        issued_d = issued_q + IW'(1);
        if (bx_q == BXW'(LINE_BURSTS - 1)) begin
          bx_d       = '0;
          row_base_d = row_base_q + ADDR_W'(stride_q);
        end else begin
          bx_d = bx_q + BXW'(1);
        end
      end
      // A pending request is held with its address until accepted.
      if (!arvalid_q || ar_hs) begin
        arvalid_d = (issued_d < IW'(FRAME_BURSTS)) && (outst_d < OW'(MAX_OUT));
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      row_base_q <= '0;
      stride_q   <= '0;
      bx_q       <= '0;
      issued_q   <= '0;
      outst_q    <= '0;
      arvalid_q  <= 1'b0;
    end else begin
      row_base_q <= row_base_d;
      stride_q   <= stride_d;
      bx_q       <= bx_d;
      issued_q   <= issued_d;
      outst_q    <= outst_d;
      arvalid_q  <= arvalid_d;
    end
  end

endmodule

// File: rtl/load_image_1280x1024.sv
// Frame reader: fetches one frame over AXI4 read and forwards it unbuffered
// as an AXI4-Stream video stream with start-of-frame and end-of-line flags.
module load_image_1280x1024 #(
  parameter int WIDTH     = load_image_pkg::WIDTH,
  parameter int HEIGHT    = load_image_pkg::HEIGHT,
  parameter int BURST_LEN = load_image_pkg::BURST_LEN,
  parameter int MAX_OUT   = load_image_pkg::MAX_OUT,
  parameter int ADDR_W    = load_image_pkg::ADDR_W
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              err,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       stride,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [31:0]       m_axis_video_tdata,
  output logic              m_axis_video_tvalid,
  input  logic              m_axis_video_tready,
  output logic              m_axis_video_tuser,
  output logic              m_axis_video_tlast
);
  import load_image_pkg::*;

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_t         state_q, state_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic           err_q, err_d;

  logic run, start_acc, hs, last_x, last_y, last_beat, beat_bad;

  assign run       = (state_q == RUN);
  assign start_acc = (state_q == IDLE) & ap_start;
  assign hs        = run & m_axi_rvalid & m_axis_video_tready;
  assign last_x    = (x_q == XW'(WIDTH - 1));
  assign last_y    = (y_q == YW'(HEIGHT - 1));
  assign last_beat = (beat_q == BW'(BURST_LEN - 1));
  // Counters follow the beat count; a misplaced or missing rlast only flags.
  assign beat_bad  = (m_axi_rresp != 2'b00) | (m_axi_rlast != last_beat);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    beat_d  = beat_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (ap_start) begin
          state_d = RUN;
          x_d     = '0;
          y_d     = '0;
          beat_d  = '0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (hs) begin
          if (beat_bad) err_d = 1'b1;
          beat_d = last_beat ? '0 : beat_q + BW'(1);
          if (last_x) begin
            x_d = '0;
            if (last_y) begin
              y_d     = '0;
              state_d = DONE;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  assign ap_done = (state_q == DONE);
  assign ap_idle = (state_q == IDLE);
  // The offending beat already shows the flag in its own cycle.
  assign err     = err_q | (hs & beat_bad);

  assign m_axi_arlen  = 8'(BURST_LEN - 1);
  assign m_axi_arsize = 3'b010;
  assign m_axi_rready = m_axis_video_tready & run;

  assign m_axis_video_tdata  = m_axi_rdata;
  assign m_axis_video_tvalid = m_axi_rvalid & run;
  assign m_axis_video_tuser  = run & (x_q == '0) & (y_q == '0);
  assign m_axis_video_tlast  = run & last_x;

  load_image_ar_gen #(
    .WIDTH     (WIDTH),
    .HEIGHT    (HEIGHT),
    .BURST_LEN (BURST_LEN),
    .MAX_OUT   (MAX_OUT),
    .ADDR_W    (ADDR_W)
  ) u_ar_gen (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .start_i     (start_acc),
    .run_i       (run),
    .base_addr_i (base_addr),
    .stride_i    (stride),
    .r_last_hs_i (hs & m_axi_rlast),
    .arready_i   (m_axi_arready),
    .arvalid_o   (m_axi_arvalid),
    .araddr_o    (m_axi_araddr)
  );

endmodule

// File: tb/tb_load_image_1280x1024.sv
// Bench for the frame reader on a reduced 64x4 frame: a memory model serves
// bursts, and every cycle the stream is checked against the reference image.
module tb_load_image_1280x1024;

  localparam int W     = 64;
  localparam int H     = 4;
  localparam int BL    = 16;
  localparam int MO    = 4;
  localparam int AW    = 32;
  localparam int TOTAL = W * H;
  localparam int NB    = TOTAL / BL;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic          ap_start = 1'b0;
  logic          ap_done, ap_idle, err;
  logic [AW-1:0] base_addr = '0;
  logic [15:0]   stride = '0;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b0;
  logic [31:0]   m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = '0;
  logic          m_axi_rlast = 1'b0;
  logic          m_axi_rvalid = 1'b0;
  logic          m_axi_rready;
  logic [31:0]   m_axis_video_tdata;
  logic          m_axis_video_tvalid;
  logic          m_axis_video_tready = 1'b0;
  logic          m_axis_video_tuser, m_axis_video_tlast;

  always #5 ap_clk = ~ap_clk;

  load_image_1280x1024 #(
    .WIDTH(W), .HEIGHT(H), .BURST_LEN(BL), .MAX_OUT(MO), .ADDR_W(AW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .err(err), .base_addr(base_addr), .stride(stride),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_video_tdata(m_axis_video_tdata), .m_axis_video_tvalid(m_axis_video_tvalid),
    .m_axis_video_tready(m_axis_video_tready), .m_axis_video_tuser(m_axis_video_tuser),
    .m_axis_video_tlast(m_axis_video_tlast)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] baddr_q[$];
  int          brdy_q[$];
  logic [31:0] ar_log[$];
  int          rbeat = 0, cyc = 0, outst = 0, pix = 0, final_cyc = -10, done_cnt = 0;
  bit          active = 0, err_sticky = 0, stall_prev = 0, first_ar = 0;
  logic [31:0] stall_addr = '0, cur_base = '0;
  logic [15:0] cur_stride = '0;
  int          lat = 1, err_beat = -1, early_burst = -1;
  bit          ar_rand = 0, tr_rand = 0;

  function automatic logic [31:0] pix_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ap_done"}, 32'(ap_done), 32'd0);
    chk({tag, "_ap_idle"}, 32'(ap_idle), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_arvalid"}, 32'(m_axi_arvalid), 32'd0);
    chk({tag, "_araddr"}, m_axi_araddr, 32'h0);
    chk({tag, "_rready"}, 32'(m_axi_rready), 32'd0);
    chk({tag, "_tvalid"}, 32'(m_axis_video_tvalid), 32'd0);
    chk({tag, "_tuser"}, 32'(m_axis_video_tuser), 32'd0);
    chk({tag, "_tlast"}, 32'(m_axis_video_tlast), 32'd0);
  endtask

  // One clock: drive memory/sink, compare every output, book handshakes.
  task automatic step(input bit start);
    logic [31:0] exp_addr;
    bit bad, done_exp, idle_exp, ar_hs, r_hs, accepted;
    ap_start = start;
    m_axi_arready = ar_rand ? ($urandom_range(0, 3) == 0) : 1'b1;
    m_axis_video_tready = tr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (baddr_q.size() > 0 && cyc >= brdy_q[0]) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = pix_data(baddr_q[0] + 32'(4 * rbeat));
      m_axi_rlast  = (pix / BL == early_burst) ? (rbeat == 7) : (rbeat == BL - 1);
      m_axi_rresp  = (pix == err_beat) ? 2'b10 : 2'b00;
    end else begin
      m_axi_rvalid = 1'b0;
      m_axi_rdata  = '0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
    end
    #1;
    done_exp = (cyc == final_cyc + 1);
    idle_exp = !active && !done_exp;
    chk("ap_done", 32'(ap_done), 32'(done_exp));
    chk("ap_idle", 32'(ap_idle), 32'(idle_exp));
    chk("rready", 32'(m_axi_rready), 32'(active && m_axis_video_tready));
    chk("tvalid", 32'(m_axis_video_tvalid), 32'(active && m_axi_rvalid));
    chk("tuser", 32'(m_axis_video_tuser), 32'(active && pix == 0));
    chk("tlast", 32'(m_axis_video_tlast), 32'(active && (pix % W == W - 1)));
    if (active && m_axi_rvalid) begin
      exp_addr = cur_base + 32'(pix / W) * 32'(cur_stride) + 32'(4 * (pix % W));
      chk("tdata", m_axis_video_tdata, pix_data(exp_addr));
    end
    r_hs = active && m_axi_rvalid && m_axis_video_tready;
    bad  = r_hs && ((m_axi_rresp != 2'b00) || (m_axi_rlast != (pix % BL == BL - 1)));
    chk("err", 32'(err), 32'(err_sticky || bad));
    if (stall_prev) begin
      chk("arvalid_hold", 32'(m_axi_arvalid), 32'd1);
      chk("araddr_hold", m_axi_araddr, stall_addr);
    end
    if (first_ar) begin
      chk("ar_first_valid", 32'(m_axi_arvalid), 32'd1);
      chk("ar_first_addr", m_axi_araddr, cur_base);
    end
    if (m_axi_arvalid) begin
      n_vec++;
      if (outst >= MO) begin
        n_err++;
        $display("FAIL max_outstanding: arvalid with %0d in flight, limit below %0d (cycle %0d)", outst, MO, cyc);
      end
    end
    chk("arlen", 32'(m_axi_arlen), 32'd15);
    ar_hs    = m_axi_arvalid && m_axi_arready;
    accepted = start && idle_exp;
    if (ar_hs) begin
      baddr_q.push_back(m_axi_araddr);
      brdy_q.push_back(cyc + lat);
      ar_log.push_back(m_axi_araddr);
      outst++;
    end
    if (r_hs) begin
      if (m_axi_rlast) outst--;
      if (bad) err_sticky = 1'b1;
      rbeat++;
      if (rbeat == BL) begin
        rbeat = 0;
        void'(baddr_q.pop_front());
        void'(brdy_q.pop_front());
      end
      pix++;
      if (pix == TOTAL) final_cyc = cyc;
    end
    if (ap_done) done_cnt++;
    stall_prev = m_axi_arvalid && !m_axi_arready;
    stall_addr = m_axi_araddr;
    first_ar   = 1'b0;
    @(posedge ap_clk);
    #1;
    cyc++;
    if (accepted) begin
      active     = 1'b1;
      err_sticky = 1'b0;
      first_ar   = 1'b1;
      pix        = 0;
    end
    if (r_hs && pix == TOTAL) active = 1'b0;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    #1;
    check_reset_vals("midframe_rst");
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    baddr_q.delete();
    brdy_q.delete();
    rbeat = 0; outst = 0; pix = 0; final_cyc = -10;
    active = 0; err_sticky = 0; stall_prev = 0; first_ar = 0;
    @(posedge ap_clk);
    #1;
    cyc++;
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    cyc++;
    $display("reset applied mid-frame at cycle %0d", cyc);
  endtask

  task automatic run_frame(input string tag, input logic [31:0] base, input logic [15:0] strd,
                           input int lt, input bit arr, input bit trr,
                           input int eb, input int ebu, input int rst_pix);
    int budget;
    cur_base = base; cur_stride = strd; lat = lt; ar_rand = arr; tr_rand = trr;
    err_beat = eb; early_burst = ebu;
    base_addr = base; stride = strd;
    ar_log.delete();
    done_cnt = 0; final_cyc = -10;
    step(1'b1);
    base_addr = 32'hDEAD_BEC0;
    stride    = 16'd64;
    budget = 0;
    while (!(final_cyc >= 0 && cyc > final_cyc + 2) && budget < 20000) begin
      if (rst_pix >= 0 && active && pix >= rst_pix) begin
        do_reset();
        return;
      end
      step(1'b0);
      budget++;
    end
    if (budget >= 20000) begin
      n_vec++; n_err++;
      $display("FAIL frame_timeout %s: %0d beats after %0d cycles, required %0d beats", tag, pix, budget, TOTAL);
    end
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, "_ar_count"}, 32'(ar_log.size()), 32'(NB));
    chk({tag, "_beats"}, 32'(pix), 32'(TOTAL));
    $display("frame %s: base 0x%08h stride %0d beats %0d bursts %0d err %0b cycle %0d",
             tag, base, strd, pix, ar_log.size(), err, cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge ap_clk);
    #1;
    check_reset_vals("por");
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;

    run_frame("ideal", 32'h1000_0000, 16'd256, 2, 0, 0, -1, -1, -1);
    if (ar_log.size() == NB) begin
      chk("ideal_ar0", ar_log[0], 32'h1000_0000);
      chk("ideal_ar1", ar_log[1], 32'h1000_0040);
      chk("ideal_ar4", ar_log[4], 32'h1000_0100);
    end

    run_frame("stride8k", 32'h1000_0000, 16'd8192, 3, 0, 0, -1, -1, -1);
    if (ar_log.size() == NB) begin
      chk("stride8k_line1", ar_log[4], 32'h1000_2000);
      chk("stride8k_last", ar_log[NB-1], 32'h1000_60C0);
    end

    run_frame("stall", 32'h2000_0040, 16'd512, 200, 1, 0, -1, -1, -1);
    run_frame("backpressure", 32'h3000_0000, 16'd256, 5, 0, 1, -1, -1, -1);

    run_frame("errors", 32'h1000_0000, 16'd256, 2, 0, 0, 50, 5, -1);
    chk("err_held_idle", 32'(err), 32'd1);

    run_frame("reset", 32'h4000_0000, 16'd256, 1, 0, 0, -1, -1, 100);
    run_frame("after_reset", 32'h4000_0000, 16'd320, 1, 0, 1, -1, -1, -1);
    run_frame("wrap", 32'hFFFF_FF00, 16'd8192, 2, 1, 1, -1, -1, -1);
    if (ar_log.size() == NB) chk("wrap_line1", ar_log[4], 32'h0000_1F00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
